spi_reg_ctrl: RTL

Transaction controller and register bank for the SPI target. Sits directly behind `spi_slave` and consumes its address, data and valid strobes. Decodes each SPI frame as a register read or write, sources read data back through `tx_d`/`tx_en`, and commits writes to a bank of 8-bit configuration registers that drive the FPGA datapath.

---
 rtl/spi_reg_pkg.sv | 27 ++
 rtl/spi_reg_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register controller.
// Used by spi_reg_ctrl (optional feature macro: SPI_REG_CTRL_ERRCNT_EN).
package spi_reg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_WAIT,
        RD_LOAD,
        RD_HOLD,
        WR_WAIT,
        WR_COMMIT,
        DONE
    } spi_ctrl_state_t;

    localparam logic [6:0] ADDR_ID     = 7'h7F;
    localparam logic [6:0] ADDR_ERRCNT = 7'h7E;

    // Widest bank supported; cfg_byte takes a bank zero-padded to this size.
    localparam int CFG_MAX_REGS = 64;

    // Slice byte n out of a flattened config bank.
    function automatic logic [7:0] cfg_byte(input logic [CFG_MAX_REGS*8-1:0] bus,
                                            input logic [5:0]                n);
        return bus[{n, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/spi_reg_ctrl.sv
// SPI transaction controller and 8-bit config register bank.
// Decodes each frame from spi_slave as a read (tx_d/tx_en) or a write
// (cfg_regs, wr_stb/wr_addr/wr_data).
// Optional build macro SPI_REG_CTRL_ERRCNT_EN adds a saturating error
// counter for unmapped accesses, readable at 0x7E and cleared by writing it.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | between frames, waiting for an addr_dv rising edge
// ADDR_WAIT | down-counting ADDR_DLY cycles until reg_addr is settled
// RD_LOAD   | tx_d holds decoded read data, tx_en still low
// RD_HOLD   | tx_en high, tx_d held until addr_dv falls
// WR_WAIT   | waiting for an rxdv rising edge
// WR_COMMIT | one cycle: write rx_d to the bank (if mapped)
// DONE      | write finished, ignoring rxdv until addr_dv falls
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int         ADDRSZ   = 7,
    parameter int         NREGS    = 16,
    parameter int         ADDR_DLY = 8,
    parameter logic [7:0] ID_VAL   = 8'hA5,
    parameter logic [7:0] CFG_RST  = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDRSZ-1:0]     reg_addr,
    input  logic                  addr_dv,
    input  logic [7:0]            rx_d,
    input  logic                  rxdv,
    input  logic                  rw_out,
    output logic [7:0]            tx_d,
    output logic                  tx_en,
    output logic [NREGS*8-1:0]    cfg_regs,
    output logic                  wr_stb,
    output logic [ADDRSZ-1:0]     wr_addr,
    output logic [7:0]            wr_data
);

    spi_ctrl_state_t           state;
    logic [5:0]                cnt;
    logic [ADDRSZ-1:0]         addr_q;
    logic                      addr_dv_q;
    logic                      rxdv_q;
    logic                      addr_rise;
    logic                      rxdv_rise;
    logic [NREGS*8-1:0]        cfg_q;
    logic [CFG_MAX_REGS*8-1:0] cfg_pad;
    logic [7:0]                rd_data;
`ifdef SPI_REG_CTRL_ERRCNT_EN
    logic [7:0]                err_cnt;
`endif

    function automatic logic is_cfg(input logic [ADDRSZ-1:0] a);
        return int'(a) < NREGS;
    endfunction

`ifdef SPI_REG_CTRL_ERRCNT_EN
    function automatic logic is_mapped(input logic [ADDRSZ-1:0] a);
        return is_cfg(a) || (a == ADDRSZ'(ADDR_ID)) || (a == ADDRSZ'(ADDR_ERRCNT));
    endfunction
`endif

    assign cfg_regs  = cfg_q;
    assign addr_rise = addr_dv & ~addr_dv_q;
    assign rxdv_rise = rxdv & ~rxdv_q;

    // Edge-detect history. addr_dv_q resets high so that an addr_dv held
    // high across reset is not taken as a new frame; a low must be seen first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_dv_q <= 1'b1;
            rxdv_q    <= 1'b0;
        end else begin
            addr_dv_q <= addr_dv;
            rxdv_q    <= rxdv;
        end
    end

    // Read mux, decoded from the live address so tx_d is registered in the
    // same cycle the address is captured.
    always_comb begin
        cfg_pad                = '0;
        cfg_pad[NREGS*8-1:0]   = cfg_q;
        rd_data                = 8'h00;
        if (is_cfg(reg_addr))
            rd_data = cfg_byte(cfg_pad, reg_addr[5:0]);
        else if (reg_addr == ADDRSZ'(ADDR_ID))
            rd_data = ID_VAL;
`ifdef SPI_REG_CTRL_ERRCNT_EN
        else if (reg_addr == ADDRSZ'(ADDR_ERRCNT))
            rd_data = err_cnt;
`endif
    end

    // Frame sequencing FSM with registered outputs and the config bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            tx_d    <= 8'h00;
            tx_en   <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'h00;
            cfg_q   <= {NREGS{CFG_RST}};
`ifdef SPI_REG_CTRL_ERRCNT_EN
            err_cnt <= 8'h00;
`endif
        end else begin
            wr_stb <= 1'b0;
            case (state)
                IDLE: begin
                    tx_en <= 1'b0;
                    if (addr_rise) begin
                        cnt   <= 6'(ADDR_DLY - 1);
                        state <= ADDR_WAIT;
                    end
                end
                ADDR_WAIT: begin
                    if (!addr_dv) begin
                        state <= IDLE;
                    end else if (cnt == 6'd0) begin
                        addr_q <= reg_addr;
                        if (rw_out) begin
                            tx_d  <= rd_data;
                            state <= RD_LOAD;
`ifdef SPI_REG_CTRL_ERRCNT_EN
                            if (!is_mapped(reg_addr) && err_cnt != 8'hFF)
                                err_cnt <= err_cnt + 8'd1;
`endif
                        end else begin
                            state <= WR_WAIT;
                        end
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                RD_LOAD: begin
                    if (!addr_dv) begin
                        state <= IDLE;
                    end else begin
                        tx_en <= 1'b1;
                        state <= RD_HOLD;
                    end
                end
                RD_HOLD: begin
                    if (!addr_dv) begin
                        tx_en <= 1'b0;
                        state <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (!addr_dv)
                        state <= IDLE;
                    else if (rxdv_rise)
                        state <= WR_COMMIT;
                end
                WR_COMMIT: begin
                    if (is_cfg(addr_q)) begin
                        for (int i = 0; i < NREGS; i++) begin
                            if (addr_q == ADDRSZ'(i))
                                cfg_q[i*8 +: 8] <= rx_d;
                        end
                        wr_stb  <= 1'b1;
                        wr_addr <= addr_q;
                        wr_data <= rx_d;
                    end
`ifdef SPI_REG_CTRL_ERRCNT_EN
                    else if (addr_q == ADDRSZ'(ADDR_ERRCNT))
                        err_cnt <= 8'h00;
                    else if (!is_mapped(addr_q) && err_cnt != 8'hFF)
                        err_cnt <= err_cnt + 8'd1;
`endif
                    state <= DONE;
                end
                DONE: begin
                    if (!addr_dv)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
